bpsk_frame_ctrl: RTL and testbench

Downstream consumer of the debounced push-button pulse in the BPSK controller/modulator path. Each debounced press starts one transmit frame: a fixed 8-bit preamble, then a DATA_W-bit payload captured from `data_in`. Bits are serialized MSB-first at a programmable bit period, with a strobe per bit for the BPSK modulator. Presses during an active frame are ignored. Completed frames are counted.

---
 rtl/bpsk_frame_ctrl.sv | 159 +++++++++++++++
 tb/tb_bpsk_frame_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/bpsk_frame_ctrl.sv
// BPSK transmit frame controller: each debounced button press sends a fixed
// 8-bit preamble followed by a latched DATA_W-bit payload, MSB-first.
module bpsk_frame_ctrl #(
   parameter int unsigned CLKS_PER_BIT = 50,
   parameter int unsigned DATA_W       = 8,
   parameter logic [7:0]  PREAMBLE     = 8'hAA
) (
   input  logic              Myclk,
   input  logic              rst,
   input  logic              btn,
   input  logic [DATA_W-1:0] data_in,
   output logic              tx_bit,
   output logic              bit_strobe,
   output logic              tx_active,
   output logic              frame_done,
   output logic [7:0]        frame_count
);

   typedef enum logic [1:0] {IDLE, PRE, DATA, DONE} state_t;

   localparam logic [15:0] TIMER_LAST = 16'(CLKS_PER_BIT - 1);
   localparam logic [5:0]  DATA_LAST  = 6'(DATA_W - 1);
   localparam logic [5:0]  PRE_LAST   = 6'd7;

   state_t            state;
   state_t            state_n;
   logic              btn_q;
   logic              press;
   logic              bit_end;
   logic [15:0]       timer;
   logic [15:0]       timer_n;
   logic [5:0]        idx;
   logic [5:0]        idx_n;
   logic [2:0]        pre_sel;
   logic [DATA_W-1:0] shreg;
   logic [DATA_W-1:0] shreg_n;
   logic              tx_bit_n;
   logic              bit_strobe_n;
   logic              tx_active_n;
   logic              frame_done_n;
   logic [7:0]        frame_count_n;

   assign press   = btn & ~btn_q;
   assign bit_end = (timer == TIMER_LAST);
   // Selects the preamble bit for the next index, i.e. PREAMBLE[7-(idx+1)].
   assign pre_sel = 3'd6 - idx[2:0];

   always_ff @(posedge Myclk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE: if (press) state_n = PRE;
         PRE:  if (bit_end && idx == PRE_LAST) state_n = DATA;
         DATA: if (bit_end && idx == DATA_LAST) state_n = DONE;
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Next values for the datapath and the registered outputs.
   always_comb begin
      timer_n       = timer;
      idx_n         = idx;
      shreg_n       = shreg;
      tx_bit_n      = tx_bit;
      tx_active_n   = tx_active;
      bit_strobe_n  = 1'b0;
      frame_done_n  = 1'b0;
      frame_count_n = frame_count;
      case (state)
         IDLE: begin
            if (press) begin
               shreg_n      = data_in;
               timer_n      = 16'd0;
               idx_n        = 6'd0;
               tx_bit_n     = PREAMBLE[7];
               tx_active_n  = 1'b1;
               bit_strobe_n = 1'b1;
            end
         end
         PRE: begin
            if (bit_end) begin
               timer_n      = 16'd0;
               bit_strobe_n = 1'b1;
               if (idx == PRE_LAST) begin
                  idx_n    = 6'd0;
                  tx_bit_n = shreg[DATA_W-1];
                  shreg_n  = shreg << 1;
               end else begin
                  idx_n    = idx + 6'd1;
                  tx_bit_n = PREAMBLE[pre_sel];
               end
            end else begin
               timer_n = timer + 16'd1;
            end
         end
         DATA: begin
            if (bit_end) begin
               timer_n = 16'd0;
               if (idx == DATA_LAST) begin
                  idx_n         = 6'd0;
                  tx_bit_n      = 1'b0;
                  tx_active_n   = 1'b0;
                  frame_done_n  = 1'b1;
                  frame_count_n = frame_count + 8'd1;
               end else begin
                  idx_n        = idx + 6'd1;
                  bit_strobe_n = 1'b1;
                  tx_bit_n     = shreg[DATA_W-1];
                  shreg_n      = shreg << 1;
               end
            end else begin
               timer_n = timer + 16'd1;
            end
         end
         DONE: begin
            tx_bit_n    = 1'b0;
            tx_active_n = 1'b0;
         end
         default: begin
            tx_bit_n    = 1'b0;
            tx_active_n = 1'b0;
         end
      endcase
   end

   // btn_q resets high so a button held through reset release is not a press.
   always_ff @(posedge Myclk or posedge rst) begin
      if (rst) begin
         btn_q       <= 1'b1;
         timer       <= 16'd0;
         idx         <= 6'd0;
         shreg       <= '0;
         tx_bit      <= 1'b0;
         bit_strobe  <= 1'b0;
         tx_active   <= 1'b0;
         frame_done  <= 1'b0;
         frame_count <= 8'd0;
      end else begin
         btn_q       <= btn;
         timer       <= timer_n;
         idx         <= idx_n;
         shreg       <= shreg_n;
         tx_bit      <= tx_bit_n;
         bit_strobe  <= bit_strobe_n;
         tx_active   <= tx_active_n;
         frame_done  <= frame_done_n;
         frame_count <= frame_count_n;
      end
   end

endmodule

// File: tb/tb_bpsk_frame_ctrl.sv
// Directed bench for bpsk_frame_ctrl: frame content and timing, press filtering,
// async reset abort, and frame counter wrap over 256 back-to-back frames.
module tb_bpsk_frame_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn = 1'b0;
   logic [7:0] data_in = 8'h3C;
   logic       tx_bit, bit_strobe, tx_active, frame_done;
   logic [7:0] frame_count;

   logic       rst2 = 1'b1;
   logic       btn2 = 1'b0;
   logic [7:0] data_in2 = 8'h5A;
   logic       tx_bit2, bit_strobe2, tx_active2, frame_done2;
   logic [7:0] frame_count2;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   bpsk_frame_ctrl #(.CLKS_PER_BIT(4), .DATA_W(8), .PREAMBLE(8'hAA)) dut (
      .Myclk(clk), .rst(rst), .btn(btn), .data_in(data_in),
      .tx_bit(tx_bit), .bit_strobe(bit_strobe), .tx_active(tx_active),
      .frame_done(frame_done), .frame_count(frame_count)
   );

   bpsk_frame_ctrl #(.CLKS_PER_BIT(2), .DATA_W(8), .PREAMBLE(8'hAA)) dut2 (
      .Myclk(clk), .rst(rst2), .btn(btn2), .data_in(data_in2),
      .tx_bit(tx_bit2), .bit_strobe(bit_strobe2), .tx_active(tx_active2),
      .frame_done(frame_done2), .frame_count(frame_count2)
   );

   task automatic apply_reset();
      btn = 1'b0;
      data_in = 8'h3C;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Samples dut for n cycles on the falling edge, optionally toggling btn or data_in.
   task automatic watch(input int n, input int drop1, input int rise1, input int drop2,
                        input int rise2, input int data_at,
                        output logic [15:0] bits, output int strobes, output int active,
                        output int dones, output int done_k, output int first_s,
                        output int bad_gap, output int unstable);
      int   prev_s = -1;
      logic prev_bit = 1'b0;
      bits = 16'h0; strobes = 0; active = 0; dones = 0;
      done_k = -1; first_s = -1; bad_gap = 0; unstable = 0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if (bit_strobe) begin
            bits = {bits[14:0], tx_bit};
            strobes++;
            if (first_s < 0) first_s = k;
            if (prev_s >= 0 && k - prev_s != 4) bad_gap++;
            prev_s = k;
         end else if (tx_active && tx_bit !== prev_bit) begin
            unstable++;
         end
         prev_bit = tx_bit;
         if (tx_active) active++;
         if (frame_done) begin
            dones++;
            if (done_k < 0) done_k = k;
         end
         if (k == drop1 || k == drop2) btn = 1'b0;
         if (k == rise1 || k == rise2) btn = 1'b1;
         if (k == data_at) data_in = 8'hFF;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      btn = 1'b0;
      #1;
      n_cmp += 5;
      if (tx_bit !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_tx_bit got %b want 0", tx_bit); end
      if (bit_strobe !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_strobe got %b want 0", bit_strobe); end
      if (tx_active !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_active got %b want 0", tx_active); end
      if (frame_done !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_done got %b want 0", frame_done); end
      if (frame_count !== 8'd0) begin n_bad++; $display("[TB] FAIL reset_count got %0d want 0", frame_count); end
   endtask

   task automatic test_single_frame();
      logic [15:0] bits;
      int s, a, d, dk, fs, bg, un;
      apply_reset();
      @(negedge clk); btn = 1'b1;
      watch(70, 2, -1, -1, -1, -1, bits, s, a, d, dk, fs, bg, un);
      n_cmp += 8;
      if (bits !== 16'hAA3C) begin n_bad++; $display("[TB] FAIL single_bits got %h want aa3c", bits); end
      if (s != 16) begin n_bad++; $display("[TB] FAIL single_strobes got %0d want 16", s); end
      if (fs != 0) begin n_bad++; $display("[TB] FAIL single_first_strobe got %0d want 0", fs); end
      if (bg != 0 || un != 0) begin n_bad++; $display("[TB] FAIL single_spacing gaps %0d unstable %0d want 0 0", bg, un); end
      if (a != 64) begin n_bad++; $display("[TB] FAIL single_active got %0d want 64", a); end
      if (d != 1) begin n_bad++; $display("[TB] FAIL single_dones got %0d want 1", d); end
      if (dk != 64) begin n_bad++; $display("[TB] FAIL single_done_cycle got %0d want 64", dk); end
      if (frame_count !== 8'd1) begin n_bad++; $display("[TB] FAIL single_count got %0d want 1", frame_count); end
   endtask

   task automatic test_data_latch();
      logic [15:0] bits;
      int s, a, d, dk, fs, bg, un;
      apply_reset();
      @(negedge clk); btn = 1'b1;
      watch(70, 2, -1, -1, -1, 1, bits, s, a, d, dk, fs, bg, un);
      n_cmp += 2;
      if (bits !== 16'hAA3C) begin n_bad++; $display("[TB] FAIL latch_bits got %h want aa3c", bits); end
      if (frame_count !== 8'd1) begin n_bad++; $display("[TB] FAIL latch_count got %0d want 1", frame_count); end
   endtask

   task automatic test_ignored_presses();
      logic [15:0] bits;
      int s, a, d, dk, fs, bg, un;
      apply_reset();
      @(negedge clk); btn = 1'b1;
      watch(140, 2, 20, 30, 64, -1, bits, s, a, d, dk, fs, bg, un);
      n_cmp += 5;
      if (bits !== 16'hAA3C) begin n_bad++; $display("[TB] FAIL ignore_bits got %h want aa3c", bits); end
      if (s != 16) begin n_bad++; $display("[TB] FAIL ignore_strobes got %0d want 16", s); end
      if (a != 64) begin n_bad++; $display("[TB] FAIL ignore_active got %0d want 64", a); end
      if (d != 1) begin n_bad++; $display("[TB] FAIL ignore_dones got %0d want 1", d); end
      if (frame_count !== 8'd1) begin n_bad++; $display("[TB] FAIL ignore_count got %0d want 1", frame_count); end
   endtask

   task automatic test_held_button();
      logic [15:0] bits;
      int s, a, d, dk, fs, bg, un;
      apply_reset();
      @(negedge clk); btn = 1'b1;
      watch(200, -1, -1, -1, -1, -1, bits, s, a, d, dk, fs, bg, un);
      n_cmp += 3;
      if (s != 16) begin n_bad++; $display("[TB] FAIL held_strobes got %0d want 16", s); end
      if (d != 1) begin n_bad++; $display("[TB] FAIL held_dones got %0d want 1", d); end
      if (frame_count !== 8'd1) begin n_bad++; $display("[TB] FAIL held_count got %0d want 1", frame_count); end
      btn = 1'b0;
      @(negedge clk); btn = 1'b1;
      watch(70, -1, -1, -1, -1, -1, bits, s, a, d, dk, fs, bg, un);
      n_cmp += 3;
      if (bits !== 16'hAA3C) begin n_bad++; $display("[TB] FAIL held2_bits got %h want aa3c", bits); end
      if (d != 1 || dk != 64) begin n_bad++; $display("[TB] FAIL held2_done got %0d at %0d want 1 at 64", d, dk); end
      if (frame_count !== 8'd2) begin n_bad++; $display("[TB] FAIL held2_count got %0d want 2", frame_count); end
   endtask

   task automatic test_reset_abort();
      logic [15:0] bits;
      int s, a, d, dk, fs, bg, un;
      apply_reset();
      @(negedge clk); btn = 1'b1;
      watch(46, -1, -1, -1, -1, -1, bits, s, a, d, dk, fs, bg, un);
      n_cmp += 2;
      if (tx_active !== 1'b1) begin n_bad++; $display("[TB] FAIL abort_active_before got %b want 1", tx_active); end
      if (s != 12) begin n_bad++; $display("[TB] FAIL abort_strobes_before got %0d want 12", s); end
      #1 rst = 1'b1;
      #1;
      n_cmp += 3;
      if (tx_active !== 1'b0 || tx_bit !== 1'b0) begin n_bad++; $display("[TB] FAIL abort_async active %b bit %b want 0 0", tx_active, tx_bit); end
      if (bit_strobe !== 1'b0 || frame_done !== 1'b0) begin n_bad++; $display("[TB] FAIL abort_async strobe %b done %b want 0 0", bit_strobe, frame_done); end
      if (frame_count !== 8'd0) begin n_bad++; $display("[TB] FAIL abort_async_count got %0d want 0", frame_count); end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      watch(80, -1, -1, -1, -1, -1, bits, s, a, d, dk, fs, bg, un);
      n_cmp += 3;
      if (s != 0 || a != 0) begin n_bad++; $display("[TB] FAIL abort_no_restart strobes %0d active %0d want 0 0", s, a); end
      if (d != 0) begin n_bad++; $display("[TB] FAIL abort_dones got %0d want 0", d); end
      if (frame_count !== 8'd0) begin n_bad++; $display("[TB] FAIL abort_count got %0d want 0", frame_count); end
      btn = 1'b0;
   endtask

   task automatic test_back_to_back();
      int         k;
      logic [7:0] want;
      rst2 = 1'b1;
      btn2 = 1'b0;
      repeat (2) @(negedge clk);
      rst2 = 1'b0;
      for (int f = 0; f < 256; f++) begin
         @(negedge clk);
         btn2 = 1'b1;
         k = 0;
         while (k < 60) begin
            @(negedge clk);
            k++;
            if (frame_done2) break;
         end
         btn2 = 1'b0;
         n_cmp++;
         if (k != 33) begin
            n_bad++;
            $display("[TB] FAIL b2b_latency frame %0d got %0d cycles want 33", f, k);
            break;
         end
         want = 8'(f + 1);
         n_cmp++;
         if (frame_count2 !== want) begin
            n_bad++;
            $display("[TB] FAIL b2b_count frame %0d got %0d want %0d", f, frame_count2, want);
         end
      end
      @(negedge clk);
      n_cmp++;
      if (frame_count2 !== 8'd0) begin n_bad++; $display("[TB] FAIL b2b_wrap got %0d want 0", frame_count2); end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_data_latch();
      test_ignored_presses();
      test_held_button();
      test_reset_abort();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
